// File: rtl/sim_ram_ctrl.sv
// Request/response front end for the SimRAM model; byte-enable writes become read-modify-write.
// Latency: read response visible 3 cycles after acceptance; full write 1 cycle; partial write 3 cycles.
// Backpressure: one request in flight, req_ready only in IDLE; response held stable until rsp_ready.
module sim_ram_ctrl #(
  parameter  int ADDR_WIDTH = 6,
  parameter  int DATA_SIZE  = 4,
  localparam int DATA_WIDTH = 8 * DATA_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]  req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RD_WAIT,
    RESP,
    RMW_RD,
    RMW_WAIT,
    WRITE
  } state_t;

  // Captured request; the write direction is folded into the next state.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_SIZE-1:0]  be;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state;
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [DATA_WIDTH-1:0] merged;

  // Byte merge for read-modify-write: new bytes where enabled, old RAM bytes elsewhere.
  always_comb begin
    merged = '0;
    for (int i = 0; i < DATA_SIZE; i++) begin
      merged[8*i +: 8] = req_q.be[i] ? req_q.wdata[8*i +: 8] : ram_rd_data[8*i +: 8];
    end
  end

  // Controller FSM: request capture, RAM sequencing and response holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q.addr  <= req_addr;
            req_q.be    <= req_be;
            req_q.wdata <= req_wdata;
            if (!req_we)             state <= READ;
            else if (&req_be)        state <= WRITE;
            else if (req_be == '0)   state <= IDLE;   // empty write: dropped, no RAM access
            else                     state <= RMW_RD;
          end
        end
        READ:     state <= RD_WAIT;
        RD_WAIT: begin
          rsp_data_q <= ram_rd_data;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        RMW_RD:   state <= RMW_WAIT;
        RMW_WAIT: begin
          req_q.wdata <= merged;
          state       <= WRITE;
        end
        WRITE:    state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state and captured request only; strobes are gated off during reset.
  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_data    = rsp_data_q;
  assign ram_rd_en   = !rst && ((state == READ) || (state == RMW_RD));
  assign ram_rd_addr = req_q.addr;
  assign ram_wr_en   = !rst && (state == WRITE);
  assign ram_wr_addr = req_q.addr;
  assign ram_wr_data = req_q.wdata;

endmodule

// File: doc/sim_ram_ctrl.md
Name: sim_ram_ctrl

Overview:
Request/response front end that sits directly upstream of the SimRAM model and drives its read and write ports. Accepts one word-addressed read or write request at a time over a valid/ready handshake. Performs byte-enable partial writes as read-modify-write, since the RAM has no byte strobes. Returns read data over a valid/ready response channel.

Parameters:
ADDR_WIDTH, 6, word address width; matches the RAM.
DATA_SIZE, 4, bytes per word.
DATA_WIDTH, 8*DATA_SIZE, word width; derived, not overridable.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  word address.
req_be  in  DATA_SIZE  byte enables; bit i covers data[8i+7:8i]; writes only.
req_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  1  read response present.
rsp_ready  in  1  consumer accepts the response.
rsp_data  out  DATA_WIDTH  read data.
ram_rd_en  out  1  to RAM rd_en.
ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
ram_rd_data  in  DATA_WIDTH  from RAM rd_data; valid the cycle after ram_rd_en (registered read).
ram_wr_en  out  1  to RAM wr_en.
ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
ram_wr_data  out  DATA_WIDTH  to RAM wr_data.

Behaviour:
- Reset: state=IDLE; addr_q, wdata_q, be_q, rsp_data=0; rsp_valid=0; req_ready=1 in the cycle after reset.
- ram_rd_en and ram_wr_en are forced to 0 in any cycle where rst=1.
- All RAM outputs decode from the state register and the captured addr_q/wdata_q. There is no combinational path from req_* to ram_*.
- One outstanding request. req_ready=1 only in IDLE.
- Acceptance: at the edge where req_valid&req_ready, capture addr, we, be, and wdata.
- States and transitions:
  - IDLE: read -> READ; write with be all ones -> WRITE; write with be=0 -> IDLE (dropped, no RAM access); any other be -> RMW_RD.
  - READ: ram_rd_en=1, ram_rd_addr=addr_q -> RD_WAIT.
  - RD_WAIT: at the edge, capture ram_rd_data into rsp_data -> RESP.
  - RESP: rsp_valid=1 -> IDLE at the edge where rsp_ready=1. rsp_data is stable while waiting.
  - RMW_RD: ram_rd_en=1, ram_rd_addr=addr_q -> RMW_WAIT.
  - RMW_WAIT: at the edge, wdata_q[byte i] = be_q[i] ? wdata_q[byte i] : ram_rd_data[byte i] -> WRITE.
  - WRITE: ram_wr_en=1, ram_wr_addr=addr_q, ram_wr_data=wdata_q -> IDLE.
- Latency, counted from the acceptance edge E:
  - Read: rsp_valid=1 in the cycle after edge E+2.
  - Full write: ram_wr_en high for exactly 1 cycle after edge E; req_ready=1 again after edge E+1.
  - Partial write: rd strobe 1 cycle, 1 wait cycle, then wr strobe 1 cycle; idle again after edge E+3.
- Writes generate no response. Ordering holds because a write completes before the next request is accepted.
- ram_rd_addr and ram_wr_addr are driven from addr_q in all states; their values do not matter when the enables are 0.
- Reset mid-operation: the operation is abandoned, no further RAM strobe is issued, and any pending response is discarded. A write whose WRITE cycle did not complete before the reset edge is not performed.
- Back-to-back reads: rsp_ready held high gives one read per 4 cycles.

Test Plan:
1. Hold rst=1 for 2 cycles with req_valid=1 -> no RAM strobes; then req_ready=1, rsp_valid=0, rsp_data=0.
2. Write addr 5, data 0xDEADBEEF, be 0xF, then read addr 5 -> ram_wr_en high for exactly 1 cycle; rsp_valid in the cycle after edge E+2, rsp_data=0xDEADBEEF.
3. After test 2, write addr 5, data 0x11223344, be 0b0101, then read addr 5 -> one ram_rd_en cycle then one ram_wr_en cycle with ram_wr_data=0xDE22BE44; read returns 0xDE22BE44.
4. Write addr 5, be 0x0 -> no ram_rd_en/ram_wr_en, req_ready high in the next cycle; read addr 5 still returns 0xDE22BE44.
5. Write 0xCAFEF00D to addr 63, read addr 63 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data=0xCAFEF00D stable, req_ready=0; transfer occurs on the edge where rsp_ready rises; req_ready=1 in the next cycle.
6. Partial write to addr 5, assert rst for 1 cycle while in RMW_WAIT -> no ram_wr_en issued; following read of addr 5 returns 0xDE22BE44.
